// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, frame length,
// default timing constants and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } ps2_tx_state_e;

  localparam int PS2_FRAME_BITS      = 11;
  localparam int PS2_INHIBIT_DEFAULT = 10000;
  localparam int PS2_TIMEOUT_DEFAULT = 2000000;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic key_clk,
  input  logic key_data,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic key_clk_p0, key_clk_p1, key_clk_p2;
  logic key_data_p0, key_data_p1;

  // Lines idle high, so the synchronizers come out of reset at 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_clk_p0  <= 1'b1;
      key_clk_p1  <= 1'b1;
      key_clk_p2  <= 1'b1;
      key_data_p0 <= 1'b1;
      key_data_p1 <= 1'b1;
    end else begin
      key_clk_p0  <= key_clk;
      key_clk_p1  <= key_clk_p0;
      key_clk_p2  <= key_clk_p1;
      key_data_p0 <= key_data;
      key_data_p1 <= key_data_p0;
    end
  end

  assign clk_s    = key_clk_p1;
  assign data_s   = key_data_p1;
  assign clk_fall = key_clk_p2 & ~key_clk_p1;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (request-to-send, 8N+parity, ack).
// Optional PS2_TX_TIMEOUT_EN adds a watchdog from request to final idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_DEFAULT
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_DEFAULT
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       key_clk_oe,
  output logic       key_data_oe,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_hold
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

  ps2_tx_state_e    state, state_n;
  logic             clk_s, data_s, clk_fall;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [3:0]       bit_cnt;
  logic [INH_W-1:0] inh_cnt;
  logic             inh_last;
  logic             data_oe_q;
  logic             ack_ok;
  logic             accept;
  logic             timeout;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .key_clk  (key_clk),
    .key_data (key_data),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  assign inh_last    = (inh_cnt == INH_W'(INHIBIT_CYCLES - 1));
  assign accept      = tx_valid & tx_ready;
  assign key_data_oe = data_oe_q;
  assign rx_hold     = (state != S_IDLE);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_active;

  assign to_active = state inside {S_REQ, S_SEND, S_ACK, S_WAIT_IDLE};
  assign timeout   = to_active && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || !to_active) to_cnt <= '0;
    else                    to_cnt <= to_cnt + TO_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    key_clk_oe = 1'b0;
    tx_ready   = 1'b0;
    tx_done    = 1'b0;
    tx_err     = 1'b0;
    case (state)
      S_IDLE: begin
        tx_ready = rst;
        if (accept) state_n = S_INHIBIT;
      end
      S_INHIBIT: begin
        key_clk_oe = 1'b1;
        if (inh_last) state_n = S_REQ;
      end
      S_REQ: begin
        key_clk_oe = 1'b1;
        state_n    = S_SEND;
      end
      S_SEND:
        if (clk_fall && bit_cnt == 4'(PS2_FRAME_BITS - 2)) state_n = S_ACK;
      S_ACK:
        if (clk_fall) state_n = S_WAIT_IDLE;
      S_WAIT_IDLE:
        if (clk_s && data_s) state_n = S_DONE;
      S_DONE: begin
        tx_done = 1'b1;
        tx_err  = ~ack_ok;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (timeout) state_n = S_DONE;
  end

  // Data is driven low one cycle before the clock is released (REQ).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      inh_cnt   <= '0;
      bit_cnt   <= '0;
      data_oe_q <= 1'b0;
      ack_ok    <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          inh_cnt   <= '0;
          bit_cnt   <= '0;
          data_oe_q <= 1'b0;
          ack_ok    <= 1'b0;
        end
        S_INHIBIT: begin
          inh_cnt <= inh_cnt + INH_W'(1);
          if (inh_last) data_oe_q <= 1'b1;
        end
        S_SEND:
          if (clk_fall) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt < 4'd8)       data_oe_q <= ~shift_q[0];
            else if (bit_cnt == 4'd8) data_oe_q <= ~parity_q;
            else                      data_oe_q <= 1'b0;
          end
        S_ACK:
          if (clk_fall) ack_ok <= ~data_s;
        default: ;
      endcase
      if (timeout) begin
        data_oe_q <= 1'b0;
        ack_ok    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q  <= tx_byte;
      parity_q <= odd_parity(tx_byte);
    end else if (state == S_SEND && clk_fall) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain line model with a scripted PS/2 device.
// Define PS2_TX_TIMEOUT_EN to also exercise the watchdog.
module tb_ps2_host_tx;

  localparam int INH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       key_clk_oe, key_data_oe, tx_ready, tx_done, tx_err, rx_hold;
  logic       line_clk, line_data;

  int checks = 0;
  int errors = 0;

  assign line_clk  = dev_clk & ~key_clk_oe;
  assign line_data = dev_data & ~key_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH)
`ifdef PS2_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES (500)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_clk     (line_clk),
    .key_data    (line_data),
    .key_clk_oe  (key_clk_oe),
    .key_data_oe (key_data_oe),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .rx_hold     (rx_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       par;
    logic       ack;
    logic       err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [7:0] b, input bit hold);
    int n;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_byte  = b;
    n = 0;
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("offer_ready", tx_ready, 1);
    @(negedge clk);
    if (!hold) tx_valid = 1'b0;
    check("accept_to_clk_oe", key_clk_oe, 1);
    check("busy_ready_low", tx_ready, 0);
    check("busy_rx_hold", rx_hold, 1);
  endtask

  task automatic check_req();
    int cnt;
    cnt = 0;
    while (key_clk_oe && !key_data_oe && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("inhibit_len", cnt, INH);
    check("req_data_before_clk", {key_clk_oe, key_data_oe}, 2'b11);
    @(negedge clk);
    check("req_clk_release", {key_clk_oe, key_data_oe}, 2'b01);
  endtask

  task automatic device(input bit ack, input int edges, output logic [9:0] bits);
    bits = '0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < edges; i++) begin
      if (i == 10) begin
        dev_data = ~ack;
        repeat (4) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (8) @(negedge clk);
      if (i < 10) bits[i] = line_data;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      if (i < edges - 1) repeat (8) @(negedge clk);
    end
  endtask

  task automatic wait_done(input logic exp_err);
    int n;
    n = 0;
    while (!tx_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", tx_done, 1);
    check("done_err", tx_err, exp_err);
    check("done_lines_released", {key_clk_oe, key_data_oe}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[4];
    logic [9:0] bits;
    int         n;

    vecs[0] = '{b: 8'hED, par: 1'b1, ack: 1'b1, err: 1'b0};
    vecs[1] = '{b: 8'h00, par: 1'b1, ack: 1'b1, err: 1'b0};
    vecs[2] = '{b: 8'h01, par: 1'b0, ack: 1'b1, err: 1'b0};
    vecs[3] = '{b: 8'hA5, par: 1'b1, ack: 1'b0, err: 1'b1};

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_oe", {key_clk_oe, key_data_oe}, 2'b00);
    check("rst_rx_hold", rx_hold, 0);
    check("rst_done_err", {tx_done, tx_err}, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", tx_ready, 1);

    for (int v = 0; v < 4; v++) begin
      offer(vecs[v].b, 1'b0);
      check_req();
      device(vecs[v].ack, 11, bits);
      check("frame_data", bits[7:0], vecs[v].b);
      check("frame_parity", bits[8], vecs[v].par);
      check("frame_stop", bits[9], 1);
      wait_done(vecs[v].err);
    end

    // Reset in the middle of SEND, then a clean 0xFF transfer.
    offer(8'h3C, 1'b0);
    check_req();
    device(1'b1, 4, bits);
    check("partial_bits", bits[3:0], 4'b1100);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_oe", {key_clk_oe, key_data_oe}, 2'b00);
    check("midrst_rx_hold", rx_hold, 0);
    check("midrst_ready", tx_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_release_ready", tx_ready, 1);
    offer(8'hFF, 1'b0);
    check_req();
    device(1'b1, 11, bits);
    check("ff_data", bits[7:0], 8'hFF);
    check("ff_parity", bits[8], 1);
    wait_done(1'b0);

    // tx_valid held through a transfer: second byte only after tx_done.
    offer(8'h01, 1'b1);
    tx_byte = 8'h00;
    check_req();
    device(1'b1, 11, bits);
    check("hold_first_data", bits[7:0], 8'h01);
    wait_done(1'b0);
    check("hold_ready_in_done", tx_ready, 0);
    @(negedge clk);
    check("hold_ready_after_done", tx_ready, 1);
    @(negedge clk);
    check("hold_second_accept", key_clk_oe, 1);
    check_req();
    tx_valid = 1'b0;
    device(1'b1, 11, bits);
    check("hold_second_data", bits[7:0], 8'h00);
    check("hold_second_parity", bits[8], 1);
    wait_done(1'b0);

`ifdef PS2_TX_TIMEOUT_EN
    offer(8'h55, 1'b0);
    check_req();
    n = 1;
    while (!tx_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 500);
    check("timeout_err", {tx_done, tx_err}, 2'b11);
    check("timeout_released", {key_clk_oe, key_data_oe}, 2'b00);
`else
    n = 0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
